// File: rtl/nn_linear_seq.sv
// nn_linear_seq: time-multiplexed fully-connected layer, y = W*x + b.
//
// LANES multiply-accumulate units are reused across G = ceil(OUT/LANES)
// output groups. Each group spends IN_FEATURES MAC cycles and one
// write-back cycle. Write-back adds the bias, rounds half-up, saturates
// and writes the group's outputs into the registered data_o.
//
// Vector ports are flat packed buses. Element i occupies
// [i*DATA_W +: DATA_W]. The weight for output o and input k is element
// (o*IN_FEATURES + k) of weight_mat.
//
// Optional build macro: NN_LINEAR_SEQ_RELU_EN enables a fused ReLU at
// write-back. When it is enabled, negative saturated results are
// written as 0.
//
// FRAC_W must be at least 1, because the rounding constant is
// 2^(FRAC_W-1).

module nn_linear_seq #(
  parameter int IN_FEATURES  = 11,
  parameter int OUT_FEATURES = 11,
  parameter int LANES        = 1,
  parameter int DATA_W       = 16,
  parameter int FRAC_W       = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [OUT_FEATURES*IN_FEATURES*DATA_W-1:0] weight_mat,
  input  logic [OUT_FEATURES*DATA_W-1:0]             bias_vec,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [IN_FEATURES*DATA_W-1:0]              data_i,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [OUT_FEATURES*DATA_W-1:0]             data_o,
  output logic                                       busy
);

  localparam int G     = (OUT_FEATURES + LANES - 1) / LANES;
  localparam int KW    = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  // Wide enough that a full dot product cannot overflow.
  localparam int ACC_W = 2 * DATA_W + $clog2(IN_FEATURES) + 1;
  // One extra bit of headroom for the bias and rounding add.
  localparam int RW    = ACC_W + 1;

  localparam logic [KW-1:0] K_LAST = KW'(IN_FEATURES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  localparam logic signed [RW-1:0] SAT_MAX =
    {{(RW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN =
    {{(RW - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic signed [RW-1:0] ROUND_C =
    {{(RW - FRAC_W){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;

  state_t                     state_q;
  logic [KW-1:0]              k_q;
  logic [GW-1:0]              g_q;
  logic [IN_FEATURES*DATA_W-1:0] x_q;
  logic signed [ACC_W-1:0]    acc_q    [LANES];

  int                         lane_o   [LANES];
  int                         lane_sel [LANES];
  logic                       lane_en  [LANES];
  logic signed [DATA_W-1:0]   w_lane   [LANES];
  logic signed [DATA_W-1:0]   b_lane   [LANES];
  logic signed [DATA_W-1:0]   x_k;
  logic signed [2*DATA_W-1:0] prod     [LANES];
  logic signed [ACC_W-1:0]    prod_ext [LANES];
  logic signed [RW-1:0]       r_sum    [LANES];
  logic signed [RW-1:0]       r_sh     [LANES];
  logic [DATA_W-1:0]          res      [LANES];

  // Per-lane operand selection, product, and write-back arithmetic.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    x_k = x_q[int'(k_q)*DATA_W +: DATA_W];
    for (int l = 0; l < LANES; l++) begin
      lane_o[l]   = int'(g_q) * LANES + l;
      lane_en[l]  = (lane_o[l] < OUT_FEATURES);
      // An idle lane in the last group reads row 0 but writes nothing.
      lane_sel[l] = lane_en[l] ? lane_o[l] : 0;
      w_lane[l]   = weight_mat[(lane_sel[l]*IN_FEATURES + int'(k_q))*DATA_W +: DATA_W];
      b_lane[l]   = bias_vec[lane_sel[l]*DATA_W +: DATA_W];
      prod[l]     = w_lane[l] * x_k;
      prod_ext[l] = {{(ACC_W - 2*DATA_W){prod[l][2*DATA_W-1]}}, prod[l]};
      r_sum[l]    = {acc_q[l][ACC_W-1], acc_q[l]}
                  + {{(RW - DATA_W - FRAC_W){b_lane[l][DATA_W-1]}}, b_lane[l], {FRAC_W{1'b0}}}
                  + ROUND_C;
      r_sh[l]     = r_sum[l] >>> FRAC_W;
      if (r_sh[l] > SAT_MAX) begin
        res[l] = SAT_MAX[DATA_W-1:0];
      end else if (r_sh[l] < SAT_MIN) begin
        res[l] = SAT_MIN[DATA_W-1:0];
      end else begin
        res[l] = r_sh[l][DATA_W-1:0];
      end
`ifdef NN_LINEAR_SEQ_RELU_EN
      if (res[l][DATA_W-1]) res[l] = '0;
`else
      res[l] = res[l];
`endif
    end
  end

  // Input vector capture at accept; data_i may change afterwards.
  // NOTE: x_q has no reset because it is always loaded on accept before it is read.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) x_q <= data_i;
  end

  // Control FSM, accumulators, and registered outputs.
  // NOTE: all sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_o    <= '0;
      k_q       <= '0;
      g_q       <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
            k_q      <= '0;
            g_q      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= S_MAC;
          end
        end
        S_MAC: begin
          for (int l = 0; l < LANES; l++) acc_q[l] <= acc_q[l] + prod_ext[l];
          if (k_q == K_LAST) begin
            state_q <= S_WB;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_WB: begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_en[l]) data_o[lane_sel[l]*DATA_W +: DATA_W] <= res[l];
            acc_q[l] <= '0;
          end
          k_q <= '0;
          if (g_q == G_LAST) begin
            out_valid <= 1'b1;
            state_q   <= S_OUT;
          end else begin
            g_q     <= g_q + 1'b1;
            state_q <= S_MAC;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            g_q       <= '0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_linear_seq.sv
// tb_nn_linear_seq: directed, table-driven bench for nn_linear_seq.
// It uses IN=4, OUT=11 and LANES=4, so G=3 and the last group uses 3 lanes.
// The expected latency is 3*(4+1)+1 = 16 cycles.
// Optional build macro: NN_LINEAR_SEQ_RELU_EN. The expected values follow it.

module tb_nn_linear_seq;

  localparam int IN_F  = 4;
  localparam int OUT_F = 11;
  localparam int LN    = 4;
  localparam int DW    = 16;
  localparam int FW    = 8;
  localparam int VW    = OUT_F * DW;
  localparam int LAT   = 3 * (IN_F + 1) + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [OUT_F*IN_F*DW-1:0] weight_mat;
  logic [OUT_F*DW-1:0]     bias_vec;
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_F*DW-1:0]      data_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [VW-1:0]           data_o;
  logic                    busy;

  logic [DW-1:0] w_m [OUT_F][IN_F];
  logic [DW-1:0] b_m [OUT_F];
  logic [DW-1:0] x_m [IN_F];

  int n_checks = 0;
  int n_err    = 0;

  nn_linear_seq #(
    .IN_FEATURES(IN_F), .OUT_FEATURES(OUT_F), .LANES(LN),
    .DATA_W(DW), .FRAC_W(FW)
  ) dut (
    .clk(clk), .rst(rst), .weight_mat(weight_mat), .bias_vec(bias_vec),
    .in_valid(in_valid), .in_ready(in_ready), .data_i(data_i),
    .out_valid(out_valid), .out_ready(out_ready), .data_o(data_o),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    weight_mat = '0;
    bias_vec   = '0;
    data_i     = '0;
    for (int o = 0; o < OUT_F; o++) begin
      bias_vec[o*DW +: DW] = b_m[o];
      for (int k = 0; k < IN_F; k++) weight_mat[(o*IN_F + k)*DW +: DW] = w_m[o][k];
    end
    for (int k = 0; k < IN_F; k++) data_i[k*DW +: DW] = x_m[k];
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    string         name;
    logic [DW-1:0] w0, w1, b, x0, x1;
    logic [DW-1:0] exp;  // before ReLU
  } vec_t;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] relu16(input logic [DW-1:0] v);
`ifdef NN_LINEAR_SEQ_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [VW-1:0] rep(input logic [DW-1:0] v);
    return {OUT_F{v}};
  endfunction

  // Reference: the exact dot product, then bias, round half up, saturate, and ReLU.
  function automatic logic [DW-1:0] model(input int o);
    longint s = 0;
    for (int k = 0; k < IN_F; k++)
      s += longint'($signed(w_m[o][k])) * longint'($signed(x_m[k]));
    s += longint'($signed(b_m[o])) * 256 + 128;
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return relu16(s[DW-1:0]);
  endfunction

  task automatic set_uniform(input logic [DW-1:0] w0, w1, b);
    for (int o = 0; o < OUT_F; o++) begin
      b_m[o] = b;
      for (int k = 0; k < IN_F; k++) w_m[o][k] = '0;
      w_m[o][0] = w0;
      w_m[o][1] = w1;
    end
  endtask

  // This task is called at a negedge while the DUT is idle. It returns at the negedge of the first cycle after the accept.
  task automatic start_vec();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // This task counts cycles after the accept cycle until out_valid is high. The wait is bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t          tbl [7];
  int            lat;
  int            bad;
  logic [VW-1:0] e;
  logic [VW-1:0] snap;

  initial begin
    tbl[0] = '{"round_up",  16'h0001, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0001};
    tbl[1] = '{"round_neg", 16'hFFFF, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000};
    tbl[2] = '{"sat_pos",   16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbl[3] = '{"sat_neg",   16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001, 16'h8000};
    tbl[4] = '{"neg_prod",  16'h0100, 16'h0000, 16'h0000, 16'hFD00, 16'h0000, 16'hFD00};
    tbl[5] = '{"bias_only", 16'h0000, 16'h0000, 16'hFF80, 16'h0000, 16'h0000, 16'hFF80};
    tbl[6] = '{"mixed",     16'h0180, 16'h0040, 16'h0080, 16'h0200, 16'hFC00, 16'h0280};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_uniform(16'h0, 16'h0, 16'h0);
    for (int k = 0; k < IN_F; k++) x_m[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  VW'(in_ready),  VW'(1));
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_busy",      VW'(busy),      VW'(0));
    check("rst_data_o",    data_o,         '0);

    // Identity on the first four outputs. Outputs 4..10 have zero rows.
    set_uniform(16'h0, 16'h0, 16'h0);
    for (int o = 0; o < IN_F; o++) w_m[o][o] = 16'h0100;
    x_m[0] = 16'h0200; x_m[1] = 16'hFD00; x_m[2] = 16'h0080; x_m[3] = 16'h7FFF;
    start_vec();
    check("ident_busy", VW'(busy), VW'(1));
    wait_out(lat);
    check("ident_latency", VW'(lat), VW'(LAT));
    e = '0;
    e[0*DW +: DW] = 16'h0200;
    e[1*DW +: DW] = relu16(16'hFD00);
    e[2*DW +: DW] = 16'h0080;
    e[3*DW +: DW] = 16'h7FFF;
    check("ident_data", data_o, e);
    @(negedge clk);
    check("ident_idle_out_valid", VW'(out_valid), VW'(0));
    check("ident_idle_in_ready",  VW'(in_ready),  VW'(1));
    check("ident_hold_data",      data_o,         e);

    // Table of scalar cases. Every row is identical, so all 11 outputs share one expectation.
    for (int i = 0; i < 7; i++) begin
      set_uniform(tbl[i].w0, tbl[i].w1, tbl[i].b);
      x_m[0] = tbl[i].x0; x_m[1] = tbl[i].x1; x_m[2] = '0; x_m[3] = '0;
      start_vec();
      wait_out(lat);
      check($sformatf("%s_lat", tbl[i].name), VW'(lat), VW'(LAT));
      check(tbl[i].name, data_o, rep(relu16(tbl[i].exp)));
      @(negedge clk);
    end

    // Lanes test: pseudo-random weights compared against the reference model, output by output.
    for (int o = 0; o < OUT_F; o++) begin
      b_m[o] = DW'($urandom_range(0, 511)) - 16'd256;
      for (int k = 0; k < IN_F; k++) w_m[o][k] = DW'($urandom_range(0, 1023)) - 16'd512;
    end
    for (int k = 0; k < IN_F; k++) x_m[k] = DW'($urandom_range(0, 4095)) - 16'd2048;
    snap = data_o;
    start_vec();
    check("lanes_hold_prev", data_o, snap);
    wait_out(lat);
    check("lanes_latency", VW'(lat), VW'(LAT));
    for (int o = 0; o < OUT_F; o++)
      check($sformatf("lanes_o%0d", o), VW'(data_o[o*DW +: DW]), VW'(model(o)));
    @(negedge clk);

    // Backpressure.
    out_ready = 1'b0;
    set_uniform(16'h0100, 16'h0, 16'h0);
    x_m[0] = 16'h0300; x_m[1] = '0; x_m[2] = '0; x_m[3] = '0;
    start_vec();
    wait_out(lat);
    check("bp_latency", VW'(lat), VW'(LAT));
    check("bp_data", data_o, rep(16'h0300));
    snap = data_o;
    x_m[0] = 16'h0500;
    in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && data_o === snap && in_ready === 1'b0 && busy === 1'b1)) bad++;
    end
    check("bp_stable_cycles_bad", VW'(bad), VW'(0));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", VW'(out_valid), VW'(0));
    check("bp_release_in_ready",  VW'(in_ready),  VW'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", VW'(in_ready), VW'(0));
    wait_out(lat);
    check("bp_second_latency", VW'(lat), VW'(LAT));
    check("bp_second_data", data_o, rep(16'h0500));
    @(negedge clk);

    // Reset while MAC is at k=3.
    x_m[0] = 16'h0700;
    start_vec();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready",  VW'(in_ready),  VW'(1));
    check("mid_rst_out_valid", VW'(out_valid), VW'(0));
    check("mid_rst_busy",      VW'(busy),      VW'(0));
    check("mid_rst_data_o",    data_o,         '0);
    set_uniform(16'h0100, 16'h0200, 16'h0);
    x_m[0] = 16'h0100; x_m[1] = 16'h0080;
    start_vec();
    wait_out(lat);
    check("post_rst_latency", VW'(lat), VW'(LAT));
    check("post_rst_data", data_o, rep(16'h0200));
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
